// File: rtl/cpu_sequencer_if.sv
// Handshake and strobe bundle between the instruction decoder/control side and cpu_sequencer.
// master drives run requests and decoded fields; slave (the sequencer) returns strobes and status.
interface cpu_sequencer_if;
    logic       start;
    logic [1:0] problem_number;
    logic       halt_req;
    logic       mem_access;
    logic       mem_write;
    logic       wr_reg;
    logic       wr_stack;
    logic       pc_en;
    logic       ir_load;
    logic       reg_en;
    logic       stack_en;
    logic       mem_we;
    logic [1:0] prob_sel;
    logic       busy;
    logic       done;

    modport master (
        output start, problem_number, halt_req, mem_access, mem_write, wr_reg, wr_stack,
        input  pc_en, ir_load, reg_en, stack_en, mem_we, prob_sel, busy, done
    );

    modport slave (
        input  start, problem_number, halt_req, mem_access, mem_write, wr_reg, wr_stack,
        output pc_en, ir_load, reg_en, stack_en, mem_we, prob_sel, busy, done
    );
endinterface

// File: rtl/cpu_sequencer.sv
// Multi-cycle CPU control sequencer: IDLE -> FETCH -> EXEC (-> MEM) -> FETCH ... -> HALTED.
// Optional run-cycle counter port enabled by defining CYCLE_COUNT_EN.
module cpu_sequencer #(
    parameter int unsigned MEM_WAIT = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    cpu_sequencer_if.slave       bus
`ifdef CYCLE_COUNT_EN
    ,
    output logic [15:0]          cycle_count
`endif
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        EXEC,
        MEM,
        HALTED
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [3:0] wait_cnt;
    logic       cap_mem_write;
    logic       cap_wr_reg;
    logic       cap_wr_stack;
    logic [1:0] prob_q;
    logic       accept;
    logic       mem_issue;

    assign accept    = ((state == IDLE) || (state == HALTED)) && bus.start;
    assign mem_issue = (state == EXEC) && !bus.halt_req && bus.mem_access;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, HALTED: if (bus.start) state_nxt = FETCH;
            FETCH:        state_nxt = EXEC;
            EXEC: begin
                if (bus.halt_req)        state_nxt = HALTED;
                else if (bus.mem_access) state_nxt = MEM;
                else                     state_nxt = FETCH;
            end
            MEM:          if (wait_cnt == 4'd1) state_nxt = FETCH;
            default:      state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.pc_en    = 1'b0;
        bus.ir_load  = 1'b0;
        bus.reg_en   = 1'b0;
        bus.stack_en = 1'b0;
        bus.mem_we   = 1'b0;
        bus.busy     = 1'b0;
        bus.done     = 1'b0;
        case (state)
            FETCH: begin
                bus.ir_load = 1'b1;
                bus.busy    = 1'b1;
            end
            EXEC: begin
                bus.busy = 1'b1;
                if (!bus.halt_req && !bus.mem_access) begin
                    bus.pc_en    = 1'b1;
                    bus.reg_en   = bus.wr_reg;
                    bus.stack_en = bus.wr_stack;
                end
            end
            MEM: begin
                bus.busy = 1'b1;
                // Write-back uses the flags captured in EXEC; decode inputs are stale here.
                if (wait_cnt == 4'd1) begin
                    bus.pc_en    = 1'b1;
                    bus.mem_we   = cap_mem_write;
                    bus.reg_en   = cap_wr_reg;
                    bus.stack_en = cap_wr_stack;
                end
            end
            HALTED:  bus.done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prob_q        <= '0;
            wait_cnt      <= '0;
            cap_mem_write <= 1'b0;
            cap_wr_reg    <= 1'b0;
            cap_wr_stack  <= 1'b0;
        end else begin
            if (accept) prob_q <= bus.problem_number;
            if (mem_issue) begin
                wait_cnt      <= 4'(MEM_WAIT);
                cap_mem_write <= bus.mem_write;
                cap_wr_reg    <= bus.wr_reg;
                cap_wr_stack  <= bus.wr_stack;
            end else if ((state == MEM) && (wait_cnt != 4'd0)) begin
                wait_cnt <= wait_cnt - 4'd1;
            end
        end
    end

    assign bus.prob_sel = prob_q;

`ifdef CYCLE_COUNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_count <= '0;
        end else if (accept) begin
            cycle_count <= '0;
        end else if (bus.busy && (cycle_count != '1)) begin
            cycle_count <= cycle_count + 16'd1;
        end
    end
`endif

endmodule
